// File: rtl/branch_predict_ctrl.sv
// Branch predictor / resolver: 2-bit BHT feeding IF, EX-stage branch
// resolution from ALU flags, redirect + flush sequencing on mispredict,
// and a saturating mispredict counter for perf debug.

// One BHT slot: 2-bit saturating counter, resets to weakly-not-taken.
module bht_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] ctr
);
  // Saturating up/down on update strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ctr <= 2'b01;
    else if (upd) begin
      if (taken && ctr != 2'b11)
        ctr <= ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
        ctr <= ctr - 2'b01;
    end
  end
endmodule

module branch_predict_ctrl #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_Z,
  input  logic        ex_C,
  input  logic        ex_V,
  input  logic        ex_S,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] mispredict_count
);
  localparam int NUM_ENT = 1 << IDX_BITS;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [NUM_ENT-1:0][1:0]    bht;
  logic [IDX_BITS-1:0]        rd_idx, wr_idx;
  logic                       legal, actual, resolve, mispredict;
  logic [15:0]                mis_cnt;
  logic                       unused_pc_bits;

  assign rd_idx         = if_pc[IDX_BITS+1:2];
  assign wr_idx         = ex_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  // Prediction reads the stored value; a same-edge write is not bypassed.
  assign if_pred_taken = bht[rd_idx][1];

  // Branch outcome from flags; funct3 010/011 are not branches
  always_comb begin
    legal  = 1'b1;
    actual = 1'b0;
    case (ex_funct3)
      3'b000:  actual = ex_Z;
      3'b001:  actual = ~ex_Z;
      3'b100:  actual = ex_S ^ ex_V;
      3'b101:  actual = ~(ex_S ^ ex_V);
      3'b110:  actual = ~ex_C;
      3'b111:  actual = ex_C;
      default: legal  = 1'b0;
    endcase
  end

  // Squashed (FLUSH) or stalled branches never resolve
  assign resolve    = ex_valid & ~stall & legal & (state_q == IDLE);
  assign mispredict = resolve & (actual != ex_pred_taken);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENT; gi++) begin : g_bht
      bht_entry u_ent (
        .clk   (clk),
        .rst   (rst),
        .upd   (resolve && (wr_idx == IDX_BITS'(gi))),
        .taken (actual),
        .ctr   (bht[gi])
      );
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: FLUSH lasts FLUSH_CYCLES cycles, counts down even when stalled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush = (state_q == FLUSH);

  // Redirect pulse and corrected fetch address, one cycle after resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict)
        redirect_pc <= actual ? ex_target : ex_pc + 32'd4;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mis_cnt <= 16'd0;
    else if (mispredict && mis_cnt != 16'hFFFF)
      mis_cnt <= mis_cnt + 16'd1;
  end

  assign mispredict_count = mis_cnt;
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Branch prediction and resolution controller for the 5-stage core. It holds a 2-bit saturating branch history table (BHT) that supplies a taken/not-taken prediction to IF. It resolves conditional branches in EX from the ALU flags using the standard RISC-V B-type funct3 encoding. On a mispredict it sequences PC redirect and pipeline flush. It also keeps a saturating mispredict counter for performance debug.

Parameters:
IDX_BITS, 4, BHT index width; the table has 2**IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
FLUSH_CYCLES, 2, number of cycles flush stays asserted after a mispredict (range 1..7).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
if_pc  input  32  PC of the instruction in IF.
if_pred_taken  output  1  combinational prediction, equal to the MSB of the BHT entry for if_pc.
ex_valid  input  1  a conditional branch is in EX this cycle.
ex_funct3  input  3  funct3 of the EX branch.
ex_Z, ex_C, ex_V, ex_S  input  1 each  ALU flags for rs1-rs2 (C=1 means no borrow).
ex_pc  input  32  PC of the EX branch.
ex_target  input  32  computed branch target.
ex_pred_taken  input  1  prediction that was piped along with the instruction.
stall  input  1  pipeline stall; when high, EX contents are not consumed.
redirect_valid  output  1  one-cycle pulse that loads redirect_pc into the PC.
redirect_pc  output  32  corrected fetch address.
flush  output  1  squashes IF/ID and ID/EX.
mispredict_count  output  16  saturating count of mispredicts.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Every BHT entry is set to 2'b01 (weakly not taken).
  - redirect_valid=0, redirect_pc=0, flush=0, mispredict_count=0.
  - The FSM goes to IDLE.
- Outcome decode (combinational):
  - 000 gives Z.
  - 001 gives ~Z.
  - 100 gives S^V.
  - 101 gives ~(S^V).
  - 110 gives ~C.
  - 111 gives C.
  - 010 and 011 are illegal encodings. They are ignored entirely: no BHT update, no redirect, no count.
- Resolve condition: resolve = ex_valid & ~stall & legal funct3 & (state==IDLE).
- BHT update happens on the clock edge where resolve=1:
  - Taken increments the entry, saturating at 11.
  - Not taken decrements the entry, saturating at 00.
- BHT read/write collision: if IF reads the same index that is being written on that edge, if_pred_taken shows the pre-update value. There is no bypass.
- Mispredict: a mispredict is resolve & (actual != ex_pred_taken). On the next edge:
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = actual ? ex_target : ex_pc+4, using 32-bit wrap-around arithmetic.
  - flush=1.
  - The FSM moves to FLUSH with its down-counter loaded with FLUSH_CYCLES-1.
  - mispredict_count increments; it holds at 16'hFFFF once reached.
- A correct prediction updates the BHT only. All outputs stay low.
- FSM behaviour:
  - IDLE: flush=0.
  - FLUSH: flush=1. The counter decrements every cycle regardless of stall. When the counter reaches 0, the FSM returns to IDLE on the next edge, so flush is high for exactly FLUSH_CYCLES cycles.
  - While in FLUSH, ex_valid is ignored because the instruction is squashed: no BHT update, no redirect.
- Stall while ex_valid is high: nothing happens. The branch resolves on the first non-stalled cycle, exactly once.
- Outputs are registered, giving a 1-cycle latency from the resolving edge to redirect_valid/flush. The exception is if_pred_taken, which is combinational from if_pc.
- Reset asserted mid-FLUSH: flush drops immediately and the BHT returns to 01 everywhere.

Test Plan:
- Reset, then if_pc=0x40 -> if_pred_taken=0; redirect_valid=0, flush=0, mispredict_count=0.
- BEQ: ex_funct3=000, Z=1, ex_pred_taken=0, ex_pc=0x100, ex_target=0x180 -> next cycle redirect_valid=1 for 1 cycle, redirect_pc=0x180; flush high for 2 cycles; count=1. Then if_pc=0x100 -> if_pred_taken=1 (entry 10).
- BLTU: ex_funct3=110, C=1 (not taken), ex_pred_taken=1, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap), flush for 2 cycles. During flush, drive ex_valid with a mispredicting branch -> no second redirect, count unchanged.
- Four consecutive taken BGE (funct3=101, S=V=0) at ex_pc=0x20, each predicted correctly from the second one on -> entry saturates at 11, redirect only for the first branch; then one not-taken branch -> entry 10, prediction stays 1.
- ex_valid=1 with stall=1 for 3 cycles, then stall=0, mispredicted BNE -> exactly one redirect, one BHT update, count +1. funct3=010 with ex_valid=1 -> no effect.
- Assert rst during the 2nd flush cycle -> flush=0 asynchronously and the BHT is cleared to 01. Force count to 0xFFFF via repeated mispredicts -> it holds at 0xFFFF.
